// File: rtl/ad9911_pkg.sv
// Shared AD9911 update-path definitions: arbiter state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ad9911_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_FTW_W   = 32;
  localparam int DEF_CH_W    = 2;
  // Per-phase handshake budget in CLOCK_10M cycles, shared with the writer and sequencers.
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HI      = 2'd1,
    LO      = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ad9911_update_arbiter_rr_pick.sv
// Round-robin picker: first set request bit searching upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [PW-1:0]    win_idx,
  output logic             win_vld
);

  function automatic logic [PW-1:0] pos(input logic [PW-1:0] p, input int k);
    return PW'((int'(p) + k) % N_REQ);
  endfunction

  // Scan from the farthest offset down so the nearest set bit to ptr is the last write.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    win_oh  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[pos(ptr, k)]) begin
        win_idx = pos(ptr, k);
        win_vld = 1'b1;
      end
    end
    if (win_vld) begin
      win_oh[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ad9911_update_arbiter.sv
// Shares the AD9911 FTW update channel among N_REQ requesters with round-robin grant and a 4-phase UPDATE/UPDATED handshake.
// Latency: REQ sampled -> UPDATE high at the next edge; ACK one cycle after UPDATED falls.
// Backpressure: requesters hold REQ until ACK/ERR; each handshake phase aborts with ERR after TIMEOUT cycles.
module ad9911_update_arbiter
  import ad9911_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int FTW_W   = DEF_FTW_W,
  parameter int CH_W    = DEF_CH_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   CLOCK_10M,
  input  logic                   RESET,
  input  logic                   INITIED,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*FTW_W-1:0] REQ_FTW,
  input  logic [N_REQ*CH_W-1:0]  REQ_CH,
  output logic [N_REQ-1:0]       ACK,
  output logic [N_REQ-1:0]       ERR,
  output logic [N_REQ-1:0]       GRANT,
  output logic                   BUSY,
  output logic                   UPDATE,
  output logic [FTW_W-1:0]       FREQW,
  output logic [CH_W-1:0]        CHSEL,
  input  logic                   UPDATED
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t        state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gidx;
  logic [PW-1:0]     ptr_next;
  logic [CW-1:0]     cnt;
  logic [N_REQ-1:0]  win_oh;
  logic [PW-1:0]     win_idx;
  logic              win_vld;
  logic              phase_expired;
  logic              can_grant;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req     (REQ),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Next round-robin start: one past the current owner, wrapping.
  assign ptr_next = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  // cnt never passes CNT_LAST, so it cannot wrap.
  assign phase_expired = (cnt == CNT_LAST);

  // ACK/ERR still high means the previous owner may not have dropped REQ yet.
  assign can_grant = INITIED && win_vld && (ACK == '0) && (ERR == '0);

  // Grant / handshake / abort FSM with all outputs registered.
  always_ff @(posedge CLOCK_10M or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      ptr    <= '0;
      gidx   <= '0;
      cnt    <= '0;
      ACK    <= '0;
      ERR    <= '0;
      GRANT  <= '0;
      BUSY   <= 1'b0;
      UPDATE <= 1'b0;
      FREQW  <= '0;
      CHSEL  <= '0;
    end else begin
      ACK <= '0;
      ERR <= '0;
      case (state)
        IDLE: begin
          if (can_grant) begin
            GRANT  <= win_oh;
            gidx   <= win_idx;
            BUSY   <= 1'b1;
            UPDATE <= 1'b1;
            FREQW  <= REQ_FTW[win_idx*FTW_W +: FTW_W];
            CHSEL  <= REQ_CH[win_idx*CH_W +: CH_W];
            cnt    <= '0;
            state  <= HI;
          end
        end
        HI: begin
          // A late UPDATED on the expiry cycle still counts as success.
          if (UPDATED) begin
            UPDATE <= 1'b0;
            cnt    <= '0;
            state  <= LO;
          end else if (phase_expired) begin
            ERR    <= GRANT;
            UPDATE <= 1'b0;
            GRANT  <= '0;
            ptr    <= ptr_next;
            state  <= RECOVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LO: begin
          if (!UPDATED) begin
            ACK   <= GRANT;
            GRANT <= '0;
            BUSY  <= 1'b0;
            ptr   <= ptr_next;
            state <= IDLE;
          end else if (phase_expired) begin
            ERR    <= GRANT;
            UPDATE <= 1'b0;
            GRANT  <= '0;
            ptr    <= ptr_next;
            state  <= RECOVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECOVER: begin
          // Hold BUSY until the writer lets go so a stale UPDATED cannot finish the next owner's handshake.
          if (!UPDATED) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
